idelay_phase_ctrl: RTL

Per-lane phase-tracking controller for the LVDS receive path. It integrates the per-word phase-detector flags produced by the master/slave ISERDES compare (increment/decrement) and drives master and slave IDELAY tap values in VAR_LOAD style. The slave delay is held a fixed half-UI ahead of the master. The block sits in the rx_clkdiv8 domain between the phase detector and the lane IDELAYE3 pair, and reports lock to the lane ready logic.

---
 rtl/idelay_phase_ctrl_if.sv | 26 ++
 rtl/idelay_phase_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/idelay_phase_ctrl_if.sv
// rtl/idelay_phase_ctrl_if.sv - phase-detector flags in, IDELAY VAR_LOAD tap bus out
interface idelay_phase_ctrl_if #(
    parameter int TAP_WIDTH = 9
);
    logic                 pd_inc;
    logic                 pd_dec;
    logic [TAP_WIDTH-1:0] m_cntvalue;
    logic [TAP_WIDTH-1:0] s_cntvalue;
    logic                 dly_load;

    modport master (
        input  pd_inc,
        input  pd_dec,
        output m_cntvalue,
        output s_cntvalue,
        output dly_load
    );

    modport slave (
        output pd_inc,
        output pd_dec,
        input  m_cntvalue,
        input  s_cntvalue,
        input  dly_load
    );
endinterface

// File: rtl/idelay_phase_ctrl.sv
// rtl/idelay_phase_ctrl.sv - per-lane IDELAY phase tracker with master/slave half-UI offset
module idelay_phase_ctrl #(
    parameter int TAP_WIDTH     = 9,
    parameter int TAP_MAX       = 511,
    parameter int HALF_UI_TAPS  = 100,
    parameter int INTEG_THRESH  = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int WINDOW_CYCLES = 64,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                        rx_clkdiv8,
    input  logic                        rx_reset_n,
    input  logic                        enable_i,
    idelay_phase_ctrl_if.master         dly_if,
    output logic                        locked_o,
    output logic                        err_limit_o,
    output logic [2:0]                  ctrl_state_o
);

    localparam int ACC_W    = $clog2(INTEG_THRESH) + 2;
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WIN_W    = $clog2(WINDOW_CYCLES + 1);
    localparam int STB_W    = $clog2(LOCK_COUNT + 1);

    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] THR_P   = ACC_W'(INTEG_THRESH);
    localparam logic signed [ACC_W-1:0] THR_N   = -THR_P;

    localparam logic [TAP_WIDTH-1:0] HALF      = TAP_WIDTH'(HALF_UI_TAPS);
    localparam logic [TAP_WIDTH-1:0] INC_LIMIT = TAP_WIDTH'(TAP_MAX - HALF_UI_TAPS);
    localparam logic [TAP_WIDTH-1:0] TAP_ONE   = TAP_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_TRACK  = 3'd3,
        S_ADJUST = 3'd4
    } state_e;

    state_e                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic                     hit_d;
    logic                     dir_up_q;
    logic [SETTLE_W-1:0]      settle_q;
    logic [WIN_W-1:0]         win_q;
    logic [STB_W-1:0]         stable_q;
    logic [TAP_WIDTH-1:0]     m_q;
    logic [TAP_WIDTH-1:0]     s_q;
    logic                     load_q;
    logic                     locked_q;
    logic                     err_q;

    // Conflicting or absent flags leave the integrator untouched.
    always_comb begin
        acc_d = acc_q;
        if (dly_if.pd_inc && !dly_if.pd_dec) begin
            acc_d = acc_q + ACC_ONE;
        end else if (dly_if.pd_dec && !dly_if.pd_inc) begin
            acc_d = acc_q - ACC_ONE;
        end
        hit_d = (acc_d == THR_P) || (acc_d == THR_N);
    end

    always_ff @(posedge rx_clkdiv8 or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            dir_up_q <= 1'b0;
            settle_q <= '0;
            win_q    <= '0;
            stable_q <= '0;
            m_q      <= '0;
            s_q      <= '0;
            load_q   <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            load_q <= 1'b0;
            if (!enable_i) begin
                // Taps and err_limit hold; everything tracking-related restarts.
                state_q  <= S_IDLE;
                locked_q <= 1'b0;
                acc_q    <= '0;
                settle_q <= '0;
                win_q    <= '0;
                stable_q <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_INIT;
                    end
                    S_INIT: begin
                        m_q      <= '0;
                        s_q      <= HALF;
                        load_q   <= 1'b1;
                        settle_q <= '0;
                        state_q  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        acc_q <= '0;
                        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                            settle_q <= '0;
                            state_q  <= S_TRACK;
                        end else begin
                            settle_q <= settle_q + SETTLE_W'(1);
                        end
                    end
                    S_TRACK: begin
                        acc_q <= acc_d;
                        if (hit_d) begin
                            dir_up_q <= ~acc_d[ACC_W-1];
                            win_q    <= '0;
                            stable_q <= '0;
                            state_q  <= S_ADJUST;
                        end else if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
                            win_q <= '0;
                            if (stable_q != STB_W'(LOCK_COUNT)) begin
                                stable_q <= stable_q + STB_W'(1);
                                if (stable_q == STB_W'(LOCK_COUNT - 1)) begin
                                    locked_q <= 1'b1;
                                end
                            end
                        end else begin
                            win_q <= win_q + WIN_W'(1);
                        end
                    end
                    S_ADJUST: begin
                        acc_q   <= '0;
                        state_q <= S_SETTLE;
                        // The increment bound keeps the slave tap at or below TAP_MAX.
                        if (dir_up_q) begin
                            if (m_q < INC_LIMIT) begin
                                m_q    <= m_q + TAP_ONE;
                                s_q    <= m_q + TAP_ONE + HALF;
                                load_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            if (m_q != '0) begin
                                m_q    <= m_q - TAP_ONE;
                                s_q    <= m_q - TAP_ONE + HALF;
                                load_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dly_if.m_cntvalue = m_q;
    assign dly_if.s_cntvalue = s_q;
    assign dly_if.dly_load   = load_q;
    assign locked_o          = locked_q;
    assign err_limit_o       = err_q;
    assign ctrl_state_o      = state_q;

endmodule
